// File: rtl/if_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : if_fetch_if                                              |
// | Purpose : instruction-memory request/ack bus between fetch and IMEM|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface if_fetch_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : if_fetch                                                 |
// | Purpose : PC owner and IMEM handshake feeding the IF/ID register.  |
// |           FETCH_ALIGN_CHK_EN adds misaligned-PC reporting.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    if_fetch_if.master  imem,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
`ifdef FETCH_ALIGN_CHK_EN
    output logic        if_adel_o,
`endif
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_READY = 2'd2,
        S_DROP  = 2'd3
    } state_t;

`ifdef FETCH_ALIGN_CHK_EN
    localparam logic [31:0] c_pc_mask = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] c_pc_mask = 32'hFFFF_FFFC;
`endif
    localparam logic [31:0] c_reset_pc = RESET_PC & c_pc_mask;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_redir, w_redir_nxt;
    logic [31:0] r_ibuf, w_ibuf_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_pend, w_pend_nxt;

    logic        w_misalign;
    logic        w_req;
    logic        w_ack;
    logic        w_fetch_ok;
    logic        w_valid;
    logic        w_advance;
    logic [31:0] w_inst;
    logic        w_unused;

    assign w_unused = &{1'b0, stall[5:1]};

`ifdef FETCH_ALIGN_CHK_EN
    assign w_misalign = (r_state == S_FETCH) && (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= c_reset_pc;
            r_redir <= '0;
            r_ibuf  <= '0;
            r_addr  <= c_reset_pc;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_redir <= w_redir_nxt;
            r_ibuf  <= w_ibuf_nxt;
            r_addr  <= w_addr_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_redir_nxt = r_redir;
        w_ibuf_nxt  = r_ibuf;
        w_pend_nxt  = r_pend;
        w_addr_nxt  = (r_state == S_FETCH) ? r_pc : r_addr;

        // A misaligned fetch never touches memory, so it counts as served.
        w_req      = ((r_state == S_FETCH) && !w_misalign) || (r_state == S_DROP);
        w_ack      = imem.inst_ack_i & w_req;
        w_fetch_ok = (r_state == S_FETCH) && (w_misalign || w_ack);
        w_valid    = w_fetch_ok || (r_state == S_READY);
        w_advance  = w_valid && !stall[0];
        w_inst     = (r_state == S_READY) ? r_ibuf :
                     (w_misalign ? 32'h0 : imem.inst_rdata_i);

        imem.inst_req_o  = w_req;
        imem.inst_addr_o = (r_state == S_DROP) ? r_addr : r_pc;
        pc_o             = w_valid ? r_pc : 32'h0;
        inst_o           = w_valid ? w_inst : 32'h0;
        stallreq_o       = !w_valid;

        if (flush) begin
            w_pc_nxt   = new_pc & c_pc_mask;
            w_pend_nxt = 1'b0;
            w_ibuf_nxt = '0;
            case (r_state)
                S_FETCH: w_state_nxt = w_fetch_ok ? S_FETCH : S_DROP;
                S_DROP:  w_state_nxt = S_DROP;
                default: w_state_nxt = S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_FETCH;
                S_FETCH: begin
                    if (w_fetch_ok && stall[0]) begin
                        w_ibuf_nxt  = w_inst;
                        w_state_nxt = S_READY;
                    end
                end
                S_DROP:  if (w_ack) w_state_nxt = S_FETCH;
                default: ;
            endcase

            if (w_advance) begin
                w_pc_nxt    = r_pend ? r_redir : r_pc + 32'd4;
                w_pend_nxt  = 1'b0;
                w_state_nxt = S_FETCH;
            end

            // Ordered after the advance so a fresh branch survives pend clearing.
            if (branch_flag_i) begin
                w_pend_nxt  = 1'b1;
                w_redir_nxt = branch_target_address_i & c_pc_mask;
            end
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic r_adel_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adel_buf <= 1'b0;
        end else if (flush) begin
            r_adel_buf <= 1'b0;
        end else if (w_fetch_ok && stall[0]) begin
            r_adel_buf <= w_misalign;
        end
    end

    assign if_adel_o = w_valid && ((r_state == S_READY) ? r_adel_buf : w_misalign);
`endif

endmodule
`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives the instruction-memory request/ack handshake.
- Absorbs memory latency and holds a fetched word while the pipeline is stalled.
- Delivers a pc/inst pair (or a zero bubble) to IF/ID, and requests a stall from the control unit while no word is available.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous active-low reset; reset asserted when 0
stall  in  6  pipeline stall vector from control; bit0 freezes this stage
flush  in  1  exception flush, highest priority
new_pc  in  32  exception handler PC, used when flush=1
branch_flag_i  in  1  taken branch/jump resolved in ID
branch_target_address_i  in  32  target for branch_flag_i
inst_req_o  out  1  instruction memory request (chip enable)
inst_addr_o  out  32  request address, word aligned
inst_ack_i  in  1  memory accepted request; inst_rdata_i valid this cycle
inst_rdata_i  in  32  returned instruction word
pc_o  out  32  PC of delivered instruction, 0 when not valid
inst_o  out  32  delivered instruction, 0 when not valid
stallreq_o  out  1  1 when no valid instruction is presented

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pc=RESET_PC; ibuf=0; pend=0.
  - inst_req_o=0; inst_addr_o=RESET_PC; pc_o=0; inst_o=0; stallreq_o=1.
- State IDLE: no request. Next state is FETCH, unconditionally. The first request therefore appears 1 cycle after reset release.
- State FETCH:
  - inst_req_o=1, inst_addr_o=pc.
  - Address and req are held stable until inst_ack_i=1.
- State READY: word held in ibuf; inst_req_o=0.
- State DROP:
  - Request still outstanding for a discarded address. inst_req_o=1, and inst_addr_o keeps the old address.
  - On ack: returned data is dropped; next state is FETCH at the current pc.
- valid = (FETCH and inst_ack_i) or READY.
  - inst_o = READY ? ibuf : inst_rdata_i.
  - pc_o = pc.
  - Both outputs are forced to 0 when valid=0.
- stallreq_o = not valid. This is combinational; it is also 1 in IDLE and DROP.
- Advance = valid and stall[0]=0.
  - pc <= pend ? redir : pc+4 (mod 2^32).
  - pend <= 0; state <= FETCH.
  - Zero-latency path: ack and advance in the same cycle; the word passes straight through.
- If valid and stall[0]=1 in FETCH: ibuf <= inst_rdata_i; state <= READY; pc unchanged.
- Branch redirect:
  - branch_flag_i=1 sets pend=1 and redir=branch_target_address_i, regardless of state or stall.
  - The redirect takes effect at the next advance, so the delay-slot instruction (current fetch) still issues.
  - branch_flag_i in the same cycle as an advance that is consuming a prior pend: the new target overwrites redir and pend stays 1.
- Flush (priority over stall, branch and advance):
  - pc <= new_pc; pend <= 0; ibuf discarded.
  - FETCH without ack -> DROP.
  - FETCH with ack, or READY or IDLE -> FETCH.
  - DROP stays DROP, but pc is updated.
- Simultaneous flush and ack: data is dropped; the next state is FETCH at new_pc.
- Reset mid-transaction: immediate return to IDLE. A late ack while in IDLE is ignored.
- inst_ack_i is ignored whenever inst_req_o=0.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - Adds output if_adel_o (1 bit).
  - If pc[1:0] != 0 in FETCH: no memory request is issued. The stage presents valid with inst_o=0 and if_adel_o=1 for that pc, then advances normally.
  - if_adel_o resets to 0.
- Undefined:
  - Port absent.
  - pc[1:0] forced to 00 on every load (reset, flush, redirect).

Test Plan:
1. Reset release, memory acks every request in the same cycle, stall=0 -> inst_req_o=0 in the first cycle. Then inst_addr_o=0x0,0x4,0x8 on consecutive cycles; pc_o/inst_o track with no bubbles; stallreq_o=0 after the first request.
2. Ack delayed 3 cycles for addr 0x4 -> inst_req_o and inst_addr_o=0x4 are held for 3 cycles; stallreq_o=1 and pc_o=inst_o=0 for 2 cycles; ack cycle delivers inst_rdata_i with pc_o=0x4.
3. Ack for 0x8 (data 0x2408_0001) with stall[0]=1 for 2 cycles -> state READY; inst_req_o=0; inst_o=0x2408_0001 held; pc stays 0x8; the release cycle advances to 0xC.
4. branch_flag_i=1, target 0x100, pulsed while the 0xC fetch waits for ack -> 0xC is still delivered (delay slot); the next request address is 0x100, not 0x10.
5. flush=1, new_pc=0x180, while the request for 0x104 is unacked -> DROP: address 0x104 is held until ack, that data is discarded, the next request is 0x180, and pc_o=0x180 on its delivery.
6. rst pulsed low during an outstanding request -> outputs return to reset values within the same cycle; the request restarts at RESET_PC one cycle after release.
